pixel_frame_capture: RTL and testbench

- Sits directly downstream of the grain-removal image engine (Picture).
- Consumes its filtered byte stream (data_valid / data_out). Picture presents a new pixel every DECIM clocks once data_valid rises.
- Decimates the stream, writes one WIDTH x HEIGHT frame into an internal byte RAM in raster order, and keeps a running checksum.
- After the frame completes, exposes a synchronous read port so a host or bench can read back the cleaned image.

---
 rtl/pixel_frame_capture.sv | 172 +++++++++++++++++
 tb/tb_pixel_frame_capture.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pixel_frame_capture                                        |
// | Description : Decimates a filtered pixel stream into one raster frame in |
// |               an internal byte RAM, with checksum and registered readback|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pixel_frame_capture #(
    parameter int WIDTH  = 223,
    parameter int HEIGHT = 223,
    parameter int DECIM  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              busy,
    output logic              frame_done,
    output logic              done,
    output logic [ADDR_W-1:0] pix_count,
    output logic [7:0]        row,
    output logic [7:0]        col,
    output logic [23:0]       checksum,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    localparam int              c_PIXELS  = WIDTH * HEIGHT;
    localparam int              c_DEPTH   = 1 << ADDR_W;
    localparam int              c_PH_W    = $clog2(DECIM);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(c_PIXELS - 1);
    localparam logic [7:0]      c_COL_MAX = 8'(WIDTH - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_PH_W-1:0] r_phase;
    logic [ADDR_W-1:0] r_pix_count;
    logic [7:0]        r_row;
    logic [7:0]        r_col;
    logic [23:0]       r_checksum;
    logic              r_last_pend;
    logic              r_frame_done;
    logic [7:0]        r_rd_data;
    logic [7:0]        r_mem [0:c_DEPTH-1];

    logic w_sample;
    logic w_clear;
    logic w_last_sample;
    logic w_finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_clear     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ARMED;
                    w_clear     = 1'b1;
                end
            end
            S_ARMED: begin
                if (in_valid) begin
                    w_sample    = 1'b1;
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // The last write lands first; the state change follows one edge later.
                if (r_last_pend) begin
                    w_state_nxt = S_DONE;
                    w_finish    = 1'b1;
                end else if (in_valid && (r_phase == '0)) begin
                    w_sample = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    w_state_nxt = S_ARMED;
                    w_clear     = 1'b1;
                end
            end
        endcase
    end

    assign w_last_sample = w_sample && (r_pix_count == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= '0;
            r_pix_count  <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_checksum   <= '0;
            r_last_pend  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_finish;
            if (w_clear) begin
                r_phase     <= '0;
                r_pix_count <= '0;
                r_row       <= '0;
                r_col       <= '0;
                r_checksum  <= '0;
                r_last_pend <= 1'b0;
            end else begin
                if (r_state == S_ARMED && in_valid) begin
                    r_phase <= c_PH_W'(1);
                end else if (r_state == S_CAPTURE && in_valid && !r_last_pend) begin
                    r_phase <= r_phase + c_PH_W'(1);
                end
                if (w_finish) begin
                    r_last_pend <= 1'b0;
                end
                if (w_sample) begin
                    r_checksum  <= r_checksum + {16'd0, in_data};
                    r_pix_count <= r_pix_count + ADDR_W'(1);
                    // Row/column freeze on the final pixel of the frame.
                    if (w_last_sample) begin
                        r_last_pend <= 1'b1;
                    end else if (r_col == c_COL_MAX) begin
                        r_col <= '0;
                        r_row <= r_row + 8'd1;
                    end else begin
                        r_col <= r_col + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_sample) begin
            r_mem[r_pix_count] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= 8'd0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign busy       = (r_state == S_ARMED) || (r_state == S_CAPTURE);
    assign done       = (r_state == S_DONE);
    assign frame_done = r_frame_done;
    assign pix_count  = r_pix_count;
    assign row        = r_row;
    assign col        = r_col;
    assign checksum   = r_checksum;
    assign rd_data    = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pixel_frame_capture                                     |
// | Description : Scoreboard bench for pixel_frame_capture on a 25x13 frame  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pixel_frame_capture;

    localparam int W  = 25;
    localparam int H  = 13;
    localparam int D  = 4;
    localparam int AW = 9;
    localparam int N  = W * H;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data  = 8'd0;
    logic [AW-1:0] rd_addr  = '0;
    logic          busy;
    logic          frame_done;
    logic          done;
    logic [AW-1:0] pix_count;
    logic [7:0]    row;
    logic [7:0]    col;
    logic [23:0]   checksum;
    logic [7:0]    rd_data;

    pixel_frame_capture #(
        .WIDTH (W),
        .HEIGHT(H),
        .DECIM (D),
        .ADDR_W(AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .busy      (busy),
        .frame_done(frame_done),
        .done      (done),
        .pix_count (pix_count),
        .row       (row),
        .col       (col),
        .checksum  (checksum),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int addr; logic [7:0] exp;} rd_t;
    typedef struct {int cyc; logic [23:0] sum;} fd_t;
    rd_t rd_q[$];
    fd_t fd_q[$];

    logic rd_req  = 1'b0;
    logic rd_pend = 1'b0;
    always @(posedge clk) rd_pend <= rd_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expected records whenever the DUT presents read data or a frame pulse.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", rd_q.size(), 1);
            end else begin
                automatic rd_t r = rd_q.pop_front();
                chk($sformatf("rd_data[%0d]", r.addr), rd_data, r.exp);
            end
        end
        if (frame_done) begin
            if (fd_q.size() == 0) begin
                chk("frame_done_spurious", frame_done, 0);
            end else begin
                automatic fd_t f = fd_q.pop_front();
                chk("fd_cycle", cyc, f.cyc);
                chk("fd_checksum", checksum, f.sum);
                chk("fd_pix_count", pix_count, N);
                chk("fd_row", row, H - 1);
                chk("fd_col", col, W - 1);
                chk("fd_done", done, 1);
                chk("fd_busy", busy, 0);
            end
        end
    end

    function automatic logic [7:0] pix(input int mode, input int e);
        case (mode)
            0:       return 8'(e >> 2);
            1:       return 8'(e);
            default: return 8'hFF;
        endcase
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic rd_check(input int addr, input logic [7:0] exp);
        rd_q.push_back('{addr, exp});
        rd_addr = AW'(addr);
        rd_req  = 1'b1;
        @(posedge clk); #1;
        rd_req  = 1'b0;
    endtask

    // Streams one frame; gap_at >= 0 drops in_valid for 7 cycles after that valid edge.
    task automatic drive(input int mode, input int gap_at, input logic [23:0] exp_sum);
        int lat = D * (N - 1) + 1 + ((gap_at >= 0) ? 7 : 0);
        for (int e = 0; e < D * (N - 1) + 9; e++) begin
            in_valid = 1'b1;
            in_data  = pix(mode, e);
            @(posedge clk); #1;
            if (e == 0) fd_q.push_back('{cyc + lat, exp_sum});
            if (mode == 1 && e == 96) begin
                chk("wrap_col", col, 0);
                chk("wrap_row", row, 1);
                chk("wrap_pix", pix_count, 25);
            end
            if (mode == 1 && e == 100) chk("wrap_col_next", col, 1);
            if (e == gap_at) begin
                in_valid = 1'b0;
                in_data  = 8'hAA;
                repeat (7) begin @(posedge clk); #1; end
                chk("gap_pix_count", pix_count, gap_at / D + 1);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && fd_q.size() != 0; i++) @(posedge clk);
        #1;
        if (fd_q.size() != 0) begin
            chk("frame_done_timeout", fd_q.size(), 0);
            fd_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_pix_count", pix_count, 0);
        chk("rst_row", row, 0);
        chk("rst_col", col, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ramp frame
        pulse_start();
        chk("armed_busy", busy, 1);
        drive(0, -1, 24'd34986);
        chk("ramp_done", done, 1);
        chk("ramp_busy", busy, 0);
        chk("ramp_sum_held", checksum, 34986);
        chk("ramp_pix_held", pix_count, N);
        rd_check(300, 8'd44);
        rd_check(0, 8'd0);
        rd_check(255, 8'd255);
        rd_check(324, 8'd68);

        // Decimation phase: data changes every clock
        pulse_start();
        chk("restart_done_drop", done, 0);
        chk("restart_sum_clear", checksum, 0);
        chk("restart_pix_clear", pix_count, 0);
        drive(1, -1, 24'd40360);
        rd_check(1, 8'd4);
        rd_check(2, 8'd8);
        rd_check(65, 8'd4);
        rd_check(324, 8'd16);

        // Valid gap after pixel 100
        pulse_start();
        drive(0, 400, 24'd34986);
        rd_check(100, 8'd100);
        rd_check(101, 8'd101);

        // Constant 0xFF frame
        pulse_start();
        chk("ff_done_drop", done, 0);
        drive(2, -1, 24'd82875);
        rd_check(0, 8'hFF);
        rd_check(324, 8'hFF);

        // Async reset at pixel 200
        pulse_start();
        for (int e = 0; e <= 800; e++) begin
            in_valid = 1'b1;
            in_data  = pix(0, e);
            @(posedge clk); #1;
        end
        chk("pre_reset_pix", pix_count, 201);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_pix_count", pix_count, 0);
        chk("arst_row", row, 0);
        chk("arst_col", col, 0);
        chk("arst_checksum", checksum, 0);
        chk("arst_rd_data", rd_data, 0);
        in_data = 8'h55;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("nostart_pix", pix_count, 0);
        chk("nostart_busy", busy, 0);
        chk("nostart_sum", checksum, 0);
        rd_check(0, 8'd0);
        rd_check(200, 8'd200);
        rd_check(201, 8'hFF);
        pulse_start();
        drive(0, -1, 24'd34986);
        rd_check(300, 8'd44);

        repeat (3) @(posedge clk);
        #1;
        chk("rd_queue_drained", rd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
